// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Runs the per-frame state machine on top of an external edge/bit counter:
// starts and clears the counter, majority-votes three mid-bit samples of
// rx_in, checks start/parity/stop, and shifts in 8 data bits LSB first.
// A good frame updates p_data with a one-cycle data_valid pulse; a bad one
// raises par_err and/or stop_err for one cycle and leaves p_data alone.
module uart_rx_frame_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  cnt_enable,
  output logic                  cnt_clr,
  output logic [7:0]            p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  logic [7:0]  shift;
  logic [2:0]  samp;
  logic        par_en_q;
  logic        par_typ_q;
  logic        par_bad;

  // Sample positions are compared at twice the edge count so that the
  // mid-bit point prescale/2 needs no division: 2*edge_cnt == prescale + 2k
  // is the same as edge_cnt == H + k for the even prescale values in use.
  logic [PRESCALE_W:0] edge_x2;
  logic [PRESCALE_W:0] pre_x1;
  logic                at_samp0;
  logic                at_samp1;
  logic                at_samp2;
  logic                at_decide;
  logic                maj;
  logic                exp_par;

  assign edge_x2   = {edge_cnt, 1'b0};
  assign pre_x1    = {1'b0, prescale};
  assign at_samp0  = cnt_enable && (edge_x2 == pre_x1 - (PRESCALE_W+1)'(2));
  assign at_samp1  = cnt_enable && (edge_x2 == pre_x1);
  assign at_samp2  = cnt_enable && (edge_x2 == pre_x1 + (PRESCALE_W+1)'(2));
  assign at_decide = cnt_enable && (edge_x2 == pre_x1 + (PRESCALE_W+1)'(4));
  assign maj       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign exp_par   = par_typ_q ? ~^shift : ^shift;

  // Capture rx_in at the three sample points around mid-bit.
  // NOTE: clocked state is always assigned with <= so every flop sees the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
    end else begin
      if (at_samp0) samp[0] <= rx_in;
      if (at_samp1) samp[1] <= rx_in;
      if (at_samp2) samp[2] <= rx_in;
    end
  end

  // Frame state machine with registered counter control and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_clr    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; the branches below only
      // ever raise them, so each pulse is exactly one cycle wide.
      cnt_clr    <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_in) begin
            state      <= START;
            cnt_enable <= 1'b1;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            par_bad    <= 1'b0;
          end
        end

        START: begin
          if (at_decide && bit_cnt == 4'd0 && maj) begin
            // Line was high at mid start bit: treat as noise.
            cnt_clr    <= 1'b1;
            cnt_enable <= 1'b0;
            state      <= IDLE;
          end else if (bit_cnt == 4'd1) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_cnt == 4'd9) begin
            state <= par_en_q ? PARITY : STOP;
          end else if (at_decide) begin
            shift <= {maj, shift[7:1]};
          end
        end

        PARITY: begin
          if (at_decide) par_bad <= (maj != exp_par);
          if (bit_cnt == 4'd10) state <= STOP;
        end

        STOP: begin
          if (at_decide) begin
            stop_err <= ~maj;
            par_err  <= par_bad;
            if (maj && !par_bad) begin
              p_data     <= shift;
              data_valid <= 1'b1;
            end
            cnt_clr    <= 1'b1;
            cnt_enable <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl.
// Provides the edge/bit counter the block expects, drives serial frames
// (directed cases, then random ones), and compares the pulses and p_data
// against outcomes derived from frame contents: parity by popcount, stop
// bit value, and the expected position of the result pulse.
module tb_uart_rx_frame_ctrl;

  localparam int PW = 6;

  logic          clk;
  logic          rst_n;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          cnt_enable;
  logic          cnt_clr;
  logic [7:0]    p_data;
  logic          data_valid;
  logic          par_err;
  logic          stop_err;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          dv_n = 0;
  int          pe_n = 0;
  int          se_n = 0;
  int          clr_n = 0;
  logic [7:0]  dv_data = '0;
  int unsigned evt_cyc = 0;
  logic [7:0]  exp_pdata = '0;

  uart_rx_frame_ctrl #(.PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .cnt_enable (cnt_enable),
    .cnt_clr    (cnt_clr),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge/bit counter environment: clear wins over enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (cnt_clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (cnt_enable) begin
      if (edge_cnt == prescale - PW'(1)) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PW'(1);
      end
    end
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_n    <= dv_n + 1;
        dv_data <= p_data;
      end
      if (par_err)  pe_n  <= pe_n + 1;
      if (stop_err) se_n  <= se_n + 1;
      if (cnt_clr)  clr_n <= clr_n + 1;
      if (data_valid || par_err || stop_err) evt_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Parity bit that makes the frame correct: even parity gives an even
  // total count of ones over data + parity, odd parity an odd count.
  function automatic logic good_par(input logic [7:0] d, input logic ptyp);
    return logic'(($countones(d) + int'(ptyp)) % 2);
  endfunction

  task automatic check_resets(input string tag);
    check({tag, "_cnt_enable"}, 32'(cnt_enable), 32'(0));
    check({tag, "_cnt_clr"},    32'(cnt_clr),    32'(0));
    check({tag, "_p_data"},     32'(p_data),     32'(0));
    check({tag, "_data_valid"}, 32'(data_valid), 32'(0));
    check({tag, "_par_err"},    32'(par_err),    32'(0));
    check({tag, "_stop_err"},   32'(stop_err),   32'(0));
  endtask

  // Drive one frame, one rx_in value per clock. g_bit/g_j invert a single
  // cycle; abort_bit asserts reset in the middle of that bit; flip changes
  // par_en/par_typ after the frame has started.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic ptyp,
                            input logic pbit, input logic sbit, input int p,
                            input int g_bit, input int g_j, input int abort_bit,
                            input int idle, input logic flip);
    logic [10:0] bits;
    int          nb;
    int          b_dv, b_pe, b_se, b_clr;
    int unsigned c0;
    logic        ok;
    logic        exp_dv;
    int          exp_clr;

    par_en   = pe;
    par_typ  = ptyp;
    prescale = PW'(p);
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = d;
    if (pe) begin
      bits[9]  = pbit;
      bits[10] = sbit;
      nb = 11;
    end else begin
      bits[9] = sbit;
      nb = 10;
    end
    b_dv = dv_n; b_pe = pe_n; b_se = se_n; b_clr = clr_n;
    c0 = cyc;

    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < p; j++) begin
        if (k == abort_bit && j == p / 2) begin
          rst_n = 1'b0;
          #1;
          check_resets("abort");
          exp_pdata = '0;
          rx_in = 1'b1;
          tick(3);
          rst_n = 1'b1;
          tick(4);
          return;
        end
        rx_in = (k == g_bit && j == g_j) ? ~bits[k] : bits[k];
        if (k == 0 && j == 0) c0 = cyc;
        if (flip && k == 2 && j == 0) begin
          par_en  = 1'($urandom);
          par_typ = 1'($urandom);
        end
        tick(1);
      end
    end
    rx_in = 1'b1;
    tick(idle);

    ok     = !pe || (pbit == good_par(d, ptyp));
    exp_dv = ok && sbit;
    // A low stop bit that is still low once the block is idle again looks
    // like a new start edge, which is then rejected as a false start.
    exp_clr = (!sbit && (p / 2 + 4 < p)) ? 2 : 1;
    check("dv_count",  32'(dv_n - b_dv),   32'(exp_dv));
    check("pe_count",  32'(pe_n - b_pe),   32'(!ok));
    check("se_count",  32'(se_n - b_se),   32'(!sbit));
    check("clr_count", 32'(clr_n - b_clr), 32'(exp_clr));
    if (exp_dv) begin
      exp_pdata = d;
      check("dv_data", 32'(dv_data), 32'(d));
    end
    check("p_data", 32'(p_data), 32'(exp_pdata));
    check("latency", evt_cyc, c0 + 32'((nb - 1) * p + p / 2 + 4));
    check("enable_low", 32'(cnt_enable), 32'(0));
  endtask

  int pv [3] = '{8, 16, 32};

  initial begin
    int b_dv, b_pe, b_se, b_clr;

    rst_n    = 1'b0;
    rx_in    = 1'b1;
    prescale = PW'(8);
    par_en   = 1'b0;
    par_typ  = 1'b0;
    tick(3);
    check_resets("reset");
    rst_n = 1'b1;
    tick(3);

    // Plain 8N1 frame.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, 0, -1, 16, 1'b0);

    // Even parity, correct and then wrong parity bit.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, -1, 0, -1, 32, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16, -1, 0, -1, 32, 1'b0);

    // False start: two low cycles only.
    prescale = PW'(8);
    b_dv = dv_n; b_pe = pe_n; b_se = se_n; b_clr = clr_n;
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(20);
    check("fs_clr",    32'(clr_n - b_clr), 32'(1));
    check("fs_dv",     32'(dv_n - b_dv),   32'(0));
    check("fs_pe",     32'(pe_n - b_pe),   32'(0));
    check("fs_se",     32'(se_n - b_se),   32'(0));
    check("fs_enable", 32'(cnt_enable),    32'(0));
    check("fs_p_data", 32'(p_data),        32'(exp_pdata));

    // Stop bit low.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8, -1, 0, -1, 16, 1'b0);

    // Back-to-back frames at prescale 32.
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, 0, -1, 0, 1'b0);
    send_frame(8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, 0, -1, 64, 1'b0);

    // Glitch on data bit 3 at edge_cnt 4, reset mid-frame, clean frame.
    send_frame(8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 5, -1, 16, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, 0, 6, 16, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, 0, -1, 16, 1'b0);

    // Random frames with occasional parity/stop faults and one masked glitch.
    repeat (24) begin
      int          p;
      int          nb;
      logic [7:0]  d;
      logic        pe;
      logic        pt;
      logic        pbit;
      logic        sbit;
      p    = pv[$urandom % 3];
      d    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      pbit = good_par(d, pt) ^ ($urandom % 5 == 0);
      sbit = ($urandom % 6 != 0);
      nb   = pe ? 11 : 10;
      send_frame(d, pe, pt, pbit, sbit, p, int'($urandom % nb),
                 p / 2 + int'($urandom % 3), -1, 2 * p, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
